// File: rtl/header_remover_blocking_pkg.sv
// Shared definitions for the header remover.
// Default header width and FSM state encoding.
package header_remover_blocking_pkg;

  localparam int HDR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_MID   = 2'd1,
    ST_EXTRA = 2'd2,
    ST_DROP  = 2'd3
  } state_e;

endpackage

// File: rtl/header_remover_blocking_reg.sv
// Single-register valid/ready output stage.
// Ports: in_valid/in_data load when can_load; out_* present the register.
module axis_reg_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             can_load,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    can_load = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (can_load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/header_remover_blocking.sv
// Strips the leading flow-hash header of an AXI-stream packet onto a
// blocking side channel and re-aligns the payload down by HDR_BYTES.
// Ports: s_axis_* in, m_axis_* payload out, header* side channel,
// status_bad_hdr pulses when a frame is dropped for a truncated header.
module header_remover_blocking
  import header_remover_blocking_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int HDR_WIDTH  = HDR_WIDTH_DEF,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [STRB_WIDTH-1:0] m_axis_tkeep,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [HDR_WIDTH-1:0]  header,
  output logic [DEST_WIDTH-1:0] header_dest,
  output logic                  header_nodata,
  output logic                  header_valid,
  input  logic                  header_ready,
  output logic                  status_bad_hdr
);

  localparam int HDR_BYTES = HDR_WIDTH / 8;
  localparam int RW = DATA_WIDTH - HDR_WIDTH;
  localparam int RK = STRB_WIDTH - HDR_BYTES;
  localparam int OW = DATA_WIDTH + STRB_WIDTH
                    + DEST_WIDTH + USER_WIDTH + 1;
  localparam int HW = HDR_WIDTH + DEST_WIDTH + 1;

  state_e                state_q, state_d;
  logic [RW-1:0]         residue_q, residue_d;
  logic [RK-1:0]         rkeep_q, rkeep_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  bad_q, bad_d;

  logic                  o_vld, o_can;
  logic [DATA_WIDTH-1:0] o_tdata;
  logic [STRB_WIDTH-1:0] o_tkeep;
  logic [DEST_WIDTH-1:0] o_tdest;
  logic [USER_WIDTH-1:0] o_tuser;
  logic                  o_tlast;
  logic [OW-1:0]         o_in, o_out;

  logic                  h_vld, h_can, h_nodata;
  logic [HW-1:0]         h_in, h_out;

  logic                  fire, hdr_ok;
  logic [RW-1:0]         in_res;
  logic [RK-1:0]         in_rkeep;

  assign fire     = s_axis_tvalid && s_axis_tready;
  assign hdr_ok   = &s_axis_tkeep[HDR_BYTES-1:0];
  assign in_res   = s_axis_tdata[DATA_WIDTH-1:HDR_WIDTH];
  assign in_rkeep = s_axis_tkeep[STRB_WIDTH-1:HDR_BYTES];

  always_comb begin
    state_d       = state_q;
    residue_d     = residue_q;
    rkeep_d       = rkeep_q;
    dest_d        = dest_q;
    user_d        = user_q;
    bad_d         = 1'b0;
    s_axis_tready = 1'b0;
    o_vld         = 1'b0;
    o_tdata       = '0;
    o_tkeep       = '0;
    o_tdest       = dest_q;
    o_tuser       = user_q;
    o_tlast       = 1'b0;
    h_vld         = 1'b0;
    h_nodata      = 1'b0;
    unique case (state_q)
      ST_FIRST: begin
        // Both slots must be free: a one-beat packet can load
        // header and data in the same cycle.
        s_axis_tready = h_can && o_can;
        if (fire && !hdr_ok) begin
          bad_d   = 1'b1;
          state_d = s_axis_tlast ? ST_FIRST : ST_DROP;
        end else if (fire) begin
          h_vld     = 1'b1;
          h_nodata  = s_axis_tlast && (in_rkeep == '0);
          dest_d    = s_axis_tdest;
          user_d    = s_axis_tuser;
          residue_d = in_res;
          rkeep_d   = in_rkeep;
          o_tdest   = s_axis_tdest;
          o_tuser   = s_axis_tuser;
          if (!s_axis_tlast) begin
            state_d = ST_MID;
          end else if (in_rkeep != '0) begin
            o_vld   = 1'b1;
            o_tdata = {{HDR_WIDTH{1'b0}}, in_res};
            o_tkeep = {{HDR_BYTES{1'b0}}, in_rkeep};
            o_tlast = 1'b1;
          end
        end
      end
      ST_MID: begin
        s_axis_tready = o_can;
        if (fire) begin
          o_vld     = 1'b1;
          o_tdata   = {s_axis_tdata[HDR_WIDTH-1:0], residue_q};
          o_tkeep   = {s_axis_tkeep[HDR_BYTES-1:0], rkeep_q};
          residue_d = in_res;
          rkeep_d   = in_rkeep;
          if (s_axis_tlast) begin
            // Leftover bytes of the last beat need one more beat.
            if (in_rkeep != '0) begin
              state_d = ST_EXTRA;
            end else begin
              o_tlast = 1'b1;
              state_d = ST_FIRST;
            end
          end
        end
      end
      ST_EXTRA: begin
        if (o_can) begin
          o_vld   = 1'b1;
          o_tdata = {{HDR_WIDTH{1'b0}}, residue_q};
          o_tkeep = {{HDR_BYTES{1'b0}}, rkeep_q};
          o_tlast = 1'b1;
          state_d = ST_FIRST;
        end
      end
      ST_DROP: begin
        s_axis_tready = 1'b1;
        if (fire && s_axis_tlast) begin
          state_d = ST_FIRST;
        end
      end
      default: state_d = ST_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FIRST;
      residue_q <= '0;
      rkeep_q   <= '0;
      dest_q    <= '0;
      user_q    <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      rkeep_q   <= rkeep_d;
      dest_q    <= dest_d;
      user_q    <= user_d;
      bad_q     <= bad_d;
    end
  end

  assign o_in = {o_tdata, o_tkeep, o_tdest, o_tuser, o_tlast};
  assign h_in = {h_nodata, s_axis_tdest,
                 s_axis_tdata[HDR_WIDTH-1:0]};

  axis_reg_slice #(.WIDTH(OW)) u_data (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (o_vld),
    .in_data   (o_in),
    .can_load  (o_can),
    .out_valid (m_axis_tvalid),
    .out_data  (o_out),
    .out_ready (m_axis_tready)
  );

  axis_reg_slice #(.WIDTH(HW)) u_hdr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (h_vld),
    .in_data   (h_in),
    .can_load  (h_can),
    .out_valid (header_valid),
    .out_data  (h_out),
    .out_ready (header_ready)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tdest,
          m_axis_tuser, m_axis_tlast} = o_out;
  assign {header_nodata, header_dest, header} = h_out;
  assign status_bad_hdr = bad_q;

endmodule

// File: tb/tb_header_remover_blocking.sv
// Scoreboard bench for header_remover_blocking.
// Byte-level packet model feeds expected queues; a monitor compares.
module tb_header_remover_blocking;

  localparam int DW = 512;
  localparam int SW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tkeep = '0;
  logic [7:0]    s_axis_tdest = '0;
  logic [2:0]    s_axis_tuser = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tkeep;
  logic [7:0]    m_axis_tdest;
  logic [2:0]    m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [31:0]   header;
  logic [7:0]    header_dest;
  logic          header_nodata;
  logic          header_valid;
  logic          header_ready = 1'b0;
  logic          status_bad_hdr;

  always #5 clk = ~clk;

  header_remover_blocking dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tdest   (s_axis_tdest),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tdest   (m_axis_tdest),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .header         (header),
    .header_dest    (header_dest),
    .header_nodata  (header_nodata),
    .header_valid   (header_valid),
    .header_ready   (header_ready),
    .status_bad_hdr (status_bad_hdr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] keep;
    logic [7:0]    dest;
    logic [2:0]    user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [31:0] hdr;
    logic [7:0]  dest;
    logic        nodata;
  } hdr_t;

  beat_t exp_b[$];
  hdr_t  exp_h[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    n_bad_exp = 0;
  int    n_bad_seen = 0;
  int    ready_mode = 1;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // 0: random readies, 1: always ready, 2: driven by main
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      header_ready  = ($urandom_range(0, 3) != 0);
    end else if (ready_mode == 1) begin
      m_axis_tready = 1'b1;
      header_ready  = 1'b1;
    end
  end

  beat_t         mb;
  hdr_t          mh;
  logic [DW-1:0] mmask;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_b.size() == 0) begin
          chk("unexpected_m_beat", DW'(1), DW'(0));
        end else begin
          mb = exp_b.pop_front();
          for (int i = 0; i < SW; i++)
            mmask[i*8 +: 8] = {8{mb.keep[i]}};
          chk("m_tdata", m_axis_tdata & mmask, mb.data & mmask);
          chk("m_tkeep", DW'(m_axis_tkeep), DW'(mb.keep));
          chk("m_tdest", DW'(m_axis_tdest), DW'(mb.dest));
          chk("m_tuser", DW'(m_axis_tuser), DW'(mb.user));
          chk("m_tlast", DW'(m_axis_tlast), DW'(mb.last));
        end
      end
      if (header_valid && header_ready) begin
        if (exp_h.size() == 0) begin
          chk("unexpected_header", DW'(1), DW'(0));
        end else begin
          mh = exp_h.pop_front();
          chk("header", DW'(header), DW'(mh.hdr));
          chk("header_dest", DW'(header_dest), DW'(mh.dest));
          chk("header_nodata", DW'(header_nodata), DW'(mh.nodata));
        end
      end
      if (status_bad_hdr) n_bad_seen++;
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d,
                            input logic [SW-1:0] k,
                            input logic l,
                            input logic [7:0] dst,
                            input logic [2:0] usr);
    bit ok;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tdest  = dst;
    s_axis_tuser  = usr;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL s_axis_accept: got no tready want tready");
      finish_up();
    end
  endtask

  // Model: header = first 4 bytes, payload = the rest in 64B beats.
  task automatic send_packet(input logic [7:0] pkt[$],
                             input int first_len,
                             input logic [7:0] dst,
                             input logic [2:0] usr,
                             input bit gaps);
    int            len, off, n;
    logic [DW-1:0] d;
    logic [SW-1:0] k;
    beat_t         b;
    hdr_t          h;
    len = pkt.size();
    if (first_len == 0) first_len = (len < SW) ? len : SW;
    if (first_len < 4) begin
      n_bad_exp++;
    end else begin
      h.hdr    = {pkt[3], pkt[2], pkt[1], pkt[0]};
      h.dest   = dst;
      h.nodata = (len == 4);
      exp_h.push_back(h);
      for (off = 4; off < len; off += SW) begin
        n = (len - off < SW) ? len - off : SW;
        b.data = '0;
        for (int j = 0; j < n; j++) b.data[j*8 +: 8] = pkt[off+j];
        b.keep = (n == SW) ? '1 : SW'((65'd1 << n) - 65'd1);
        b.dest = dst;
        b.user = usr;
        b.last = (off + n == len);
        exp_b.push_back(b);
      end
    end
    off = 0;
    while (off < len) begin
      n = (off == 0) ? first_len : ((len - off < SW) ? len - off : SW);
      d = '0;
      for (int j = 0; j < n; j++) d[j*8 +: 8] = pkt[off+j];
      k = (n == SW) ? '1 : SW'((65'd1 << n) - 65'd1);
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      drive_beat(d, k, (off + n == len), dst, usr);
      off += n;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 5000; c++) begin
      if (exp_b.size() == 0 && exp_h.size() == 0) break;
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_m_tvalid"}, DW'(m_axis_tvalid), DW'(0));
    chk({tag, "_m_tdata"}, m_axis_tdata, '0);
    chk({tag, "_m_tkeep"}, DW'(m_axis_tkeep), DW'(0));
    chk({tag, "_m_tlast"}, DW'(m_axis_tlast), DW'(0));
    chk({tag, "_m_tdest"}, DW'(m_axis_tdest), DW'(0));
    chk({tag, "_hdr_valid"}, DW'(header_valid), DW'(0));
    chk({tag, "_header"}, DW'(header), DW'(0));
    chk({tag, "_nodata"}, DW'(header_nodata), DW'(0));
    chk({tag, "_bad_hdr"}, DW'(status_bad_hdr), DW'(0));
  endtask

  logic [7:0] p[$];

  task automatic fill(input int len, input bit rnd);
    p.delete();
    for (int i = 0; i < len; i++)
      p.push_back(rnd ? 8'($urandom) : 8'(i + 1));
  endtask

  initial begin
    int len, fl;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: one 64B beat, header DEADBEEF
    fill(64, 0);
    p[0] = 8'hEF; p[1] = 8'hBE; p[2] = 8'hAD; p[3] = 8'hDE;
    send_packet(p, 0, 8'h25, 3'd1, 0);
    // 2: 128B, two full beats
    fill(128, 1);
    send_packet(p, 0, 8'h31, 3'd2, 0);
    // 3: 68B, no extra beat
    fill(68, 1);
    send_packet(p, 0, 8'h42, 3'd3, 0);
    // 4: header only, runts
    fill(4, 1);
    send_packet(p, 0, 8'h53, 3'd4, 0);
    fill(2, 1);
    send_packet(p, 0, 8'h64, 3'd5, 0);
    fill(130, 1);
    send_packet(p, 2, 8'h65, 3'd5, 0);
    fill(70, 1);
    send_packet(p, 0, 8'h66, 3'd6, 0);
    drain();

    // 5: blocked header channel
    ready_mode    = 2;
    m_axis_tready = 1'b1;
    header_ready  = 1'b0;
    fill(70, 1);
    send_packet(p, 0, 8'h71, 3'd1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("blocked_tready", DW'(s_axis_tready), DW'(0));
    end
    @(posedge clk);
    #1;
    fill(100, 1);
    fork
      begin
        repeat (4) @(posedge clk);
        #1;
        header_ready = 1'b1;
      end
      send_packet(p, 0, 8'h72, 3'd2, 0);
    join
    ready_mode = 1;
    drain();

    // 6: random traffic with one mid-packet reset
    ready_mode = 0;
    for (int n = 0; n < 1000; n++) begin
      if (n == 500) begin
        ready_mode = 1;
        drain();
        ready_mode    = 2;
        m_axis_tready = 1'b0;
        header_ready  = 1'b0;
        drive_beat({16{32'h1234_5678}}, '1, 1'b0, 8'h99, 3'd7);
        drive_beat({16{32'hCAFE_F00D}}, '1, 1'b0, 8'h99, 3'd7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("post_rst");
        chk("post_rst_s_tready", DW'(s_axis_tready), DW'(1));
        @(posedge clk);
        #1;
        ready_mode = 0;
      end
      len = $urandom_range(1, 200);
      fl  = 0;
      if ($urandom_range(0, 49) == 0) begin
        fl  = $urandom_range(1, 3);
        len = fl + $urandom_range(0, 130);
      end
      fill(len, 1);
      send_packet(p, fl, 8'($urandom), 3'($urandom), 1);
    end
    ready_mode = 1;
    drain();
    chk("bad_hdr_pulses", DW'(n_bad_seen), DW'(n_bad_exp));
    chk("beats_left", DW'(exp_b.size()), DW'(0));
    chk("headers_left", DW'(exp_h.size()), DW'(0));
    finish_up();
  end

endmodule
